// File: rtl/adxl362_regs_if.sv
// Register-access bus between the ADXL362 SPI slave (master side) and the register bank.
// The strobes are levels that may change at any time relative to clk.
interface adxl362_regs_if;
    logic [5:0] address;
    logic [7:0] data_write;
    logic       write;
    logic       read;
    logic [7:0] data_read;

    modport master (
        output address,
        output data_write,
        output write,
        output read,
        input  data_read
    );

    modport slave (
        input  address,
        input  data_write,
        input  write,
        input  read,
        output data_read
    );
endinterface

// File: rtl/adxl362_regs.sv
// ADXL362 model register bank and periodic sample engine, fed by the SPI slave's strobes.
// Writes commit 3 clk after the write strobe rises; captures are held off during a read burst.
module adxl362_regs #(
    parameter int         ODR_DIVIDE = 1000,
    parameter logic [7:0] DEVID_AD   = 8'hAD,
    parameter logic [7:0] PARTID     = 8'hF2,
    parameter logic [7:0] REVID      = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    adxl362_regs_if.slave bus,
    input  logic [11:0] x_sample,
    input  logic [11:0] y_sample,
    input  logic [11:0] z_sample,
    input  logic [11:0] temp_sample,
    output logic        data_ready,
    output logic        measure_on
);
    localparam int CNT_W = (ODR_DIVIDE > 2) ? $clog2(ODR_DIVIDE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ODR_DIVIDE - 1);
    localparam logic [3:0] POWER_CTL_IDX  = 4'hD;
    localparam logic [3:0] FILTER_CTL_IDX = 4'hC;

    logic [2:0]       wr_sync;
    logic [2:0]       rd_sync;
    logic             wr_edge;
    logic             rd_edge;
    logic             rd_level;

    logic [7:0]       ctrl [15];
    logic [11:0]      x_shadow;
    logic [11:0]      y_shadow;
    logic [11:0]      z_shadow;
    logic [11:0]      temp_shadow;
    logic             status_dr;
    logic             pending;
    logic [CNT_W-1:0] cnt;

    logic             soft_rst;
    logic             ctrl_wr;
    logic             tc;
    logic             capture_due;
    logic             do_capture;
    logic             rd_clear;
    logic [7:0]       rd_mux;

    // Synchronisers are deliberately outside the soft-reset domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sync <= '0;
            rd_sync <= '0;
        end else begin
            wr_sync <= {wr_sync[1:0], bus.write};
            rd_sync <= {rd_sync[1:0], bus.read};
        end
    end

    assign wr_edge  = wr_sync[1] & ~wr_sync[2];
    assign rd_edge  = rd_sync[1] & ~rd_sync[2];
    assign rd_level = rd_sync[1];

    assign soft_rst = wr_edge && (bus.address == 6'h1F) && (bus.data_write == 8'h52);
    assign ctrl_wr  = wr_edge && (bus.address[5:4] == 2'b10) && (bus.address[3:0] != 4'hF);

    assign measure_on  = (ctrl[POWER_CTL_IDX][1:0] == 2'b10);
    assign tc          = measure_on && (cnt == CNT_LAST);
    assign capture_due = tc || pending;
    assign do_capture  = capture_due && !rd_level;
    assign rd_clear    = rd_edge &&
                         (((bus.address >= 6'h08) && (bus.address <= 6'h0A)) ||
                          ((bus.address >= 6'h0E) && (bus.address <= 6'h15)));
    assign data_ready  = status_dr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) ctrl[i] <= 8'h00;
            ctrl[FILTER_CTL_IDX] <= 8'h13;
            x_shadow    <= '0;
            y_shadow    <= '0;
            z_shadow    <= '0;
            temp_shadow <= '0;
            status_dr   <= 1'b0;
            pending     <= 1'b0;
            cnt         <= '0;
        end else if (soft_rst) begin
            for (int i = 0; i < 15; i++) ctrl[i] <= 8'h00;
            ctrl[FILTER_CTL_IDX] <= 8'h13;
            x_shadow    <= '0;
            y_shadow    <= '0;
            z_shadow    <= '0;
            temp_shadow <= '0;
            status_dr   <= 1'b0;
            pending     <= 1'b0;
            cnt         <= '0;
        end else begin
            if (ctrl_wr) ctrl[bus.address[3:0]] <= bus.data_write;

            if (!measure_on || tc) cnt <= '0;
            else                   cnt <= cnt + 1'b1;

            // Terminal counts during a read burst collapse into one pending capture.
            pending <= capture_due && rd_level;

            if (do_capture) begin
                x_shadow    <= x_sample;
                y_shadow    <= y_sample;
                z_shadow    <= z_sample;
                temp_shadow <= temp_sample;
            end

            if (do_capture)    status_dr <= 1'b1;
            else if (rd_clear) status_dr <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (bus.address)
            6'h00: rd_mux = DEVID_AD;
            6'h01: rd_mux = 8'h1D;
            6'h02: rd_mux = PARTID;
            6'h03: rd_mux = REVID;
            6'h08: rd_mux = x_shadow[11:4];
            6'h09: rd_mux = y_shadow[11:4];
            6'h0A: rd_mux = z_shadow[11:4];
            6'h0B: rd_mux = {7'b0, status_dr};
            6'h0E: rd_mux = x_shadow[7:0];
            6'h0F: rd_mux = {{4{x_shadow[11]}}, x_shadow[11:8]};
            6'h10: rd_mux = y_shadow[7:0];
            6'h11: rd_mux = {{4{y_shadow[11]}}, y_shadow[11:8]};
            6'h12: rd_mux = z_shadow[7:0];
            6'h13: rd_mux = {{4{z_shadow[11]}}, z_shadow[11:8]};
            6'h14: rd_mux = temp_shadow[7:0];
            6'h15: rd_mux = {{4{temp_shadow[11]}}, temp_shadow[11:8]};
            default: begin
                if ((bus.address[5:4] == 2'b10) && (bus.address[3:0] != 4'hF))
                    rd_mux = ctrl[bus.address[3:0]];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.data_read <= 8'h00;
        else     bus.data_read <= rd_mux;
    end
endmodule
